// File: rtl/gumnut_io_pkg.sv
// rtl/gumnut_io_pkg.sv - shared types and register map for the Gumnut I/O responder
// Purpose: bus FSM state type, register offsets and register bit positions.
// Ports: none (package).
package gumnut_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_t;

  localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
  localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
  localparam logic [2:0] OFF_RELOAD   = 3'd2;
  localparam logic [2:0] OFF_CTRL     = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam int CTRL_TMR_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STATUS_EXP  = 0;

endpackage

// File: rtl/gumnut_tick_timer.sv
// rtl/gumnut_tick_timer.sv - prescaled 8-bit reload down-counter with expiry pulse
// Purpose: prescaler wraps every PRESCALE enabled cycles (one tick); each tick
//   decrements the counter, or reloads it and pulses expire when it is 0.
// Ports: clk, rst (sync, active-high); en gates prescaler and counter;
//   load/load_val force the counter; reload is the value taken on expiry;
//   expire is high for the single cycle of a tick with counter 0.
module gumnut_tick_timer #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] reload,
  output logic       expire
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;
  logic [7:0]    cnt;
  logic          tick;

  assign tick   = en && (psc == PS_LAST);
  // Expiry is judged on the pre-edge count, so it still fires when a load
  // coincides with the tick.
  assign expire = tick && (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
      cnt <= 8'd0;
    end else begin
      if (en) begin
        psc <= tick ? '0 : psc + 1'b1;
      end
      // A load overrides whatever the tick would have done to the counter.
      if (load) begin
        cnt <= load_val;
      end else if (tick) begin
        cnt <= (cnt == 8'd0) ? reload : cnt - 8'd1;
      end
    end
  end

endmodule

// File: rtl/gumnut_io_responder.sv
// rtl/gumnut_io_responder.sv - port-bus responder with GPIO, reload timer and interrupt
// Purpose: decodes port-bus strobes, acknowledges after WAIT_STATES extra
//   cycles, and hosts GPIO_OUT, GPIO_IN, RELOAD, CTRL and STATUS registers.
// Ports: clk_i/rst_i (sync, active-high); cyc_i, stb_i, we_i, addr_i, dat_i
//   request side; dat_o, ack_o response side; int_ack_i/int_req_o interrupt
//   handshake; gpio_i/gpio_o general-purpose I/O.
module gumnut_io_responder
  import gumnut_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         WAIT_STATES = 1,
  parameter int         PRESCALE    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  input  logic       int_ack_i,
  output logic       int_req_o,
  input  logic [7:0] gpio_i,
  output logic [7:0] gpio_o
);

  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  bus_state_t state;
  logic [3:0] wcnt;
  logic [2:0] addr_q;
  logic       we_q;
  logic [7:0] dat_q;

  logic [7:0] gpio_s1, gpio_s2;
  logic [7:0] reload;
  logic       tmr_en, irq_en, exp_flag;

  logic       req, sel, wr_en, w1c, expire;
  logic [2:0] rd_off;
  logic [7:0] rd_data;

  assign req   = cyc_i & stb_i;
  assign sel   = (addr_i[7:3] == BASE_ADDR[7:3]);
  assign wr_en = (state == ACK) && we_q;
  assign w1c   = wr_en && (addr_q == OFF_STATUS) && dat_q[STATUS_EXP];

  // With zero wait states the read mux is sampled in IDLE, before addr_q holds
  // the request address.
  assign rd_off = (state == IDLE) ? addr_i[2:0] : addr_q;

  always_comb begin
    rd_data = 8'd0;
    case (rd_off)
      OFF_GPIO_OUT: rd_data = gpio_o;
      OFF_GPIO_IN:  rd_data = gpio_s2;
      OFF_RELOAD:   rd_data = reload;
      OFF_CTRL: begin
        rd_data[CTRL_TMR_EN] = tmr_en;
        rd_data[CTRL_IRQ_EN] = irq_en;
      end
      OFF_STATUS:   rd_data[STATUS_EXP] = exp_flag;
      default:      rd_data = 8'd0;
    endcase
  end

  // Bus FSM; ack_o/dat_o are registered on entry to ACK so they are valid
  // exactly while the FSM sits in ACK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      wcnt   <= 4'd0;
      addr_q <= 3'd0;
      we_q   <= 1'b0;
      dat_q  <= 8'd0;
      ack_o  <= 1'b0;
      dat_o  <= 8'd0;
    end else begin
      ack_o <= 1'b0;
      dat_o <= 8'd0;
      case (state)
        IDLE: begin
          if (req && sel) begin
            addr_q <= addr_i[2:0];
            we_q   <= we_i;
            dat_q  <= dat_i;
            wcnt   <= 4'd0;
            if (WAIT_STATES == 0) begin
              state <= ACK;
              ack_o <= 1'b1;
              dat_o <= we_i ? 8'd0 : rd_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (wcnt == WS_LAST) begin
            state <= ACK;
            ack_o <= 1'b1;
            dat_o <= we_q ? 8'd0 : rd_data;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Register file, GPIO synchroniser and interrupt flag; writes commit at the
  // end of the ACK cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpio_o    <= 8'd0;
      gpio_s1   <= 8'd0;
      gpio_s2   <= 8'd0;
      reload    <= 8'd0;
      tmr_en    <= 1'b0;
      irq_en    <= 1'b0;
      exp_flag  <= 1'b0;
      int_req_o <= 1'b0;
    end else begin
      gpio_s1 <= gpio_i;
      gpio_s2 <= gpio_s1;
      if (wr_en) begin
        case (addr_q)
          OFF_GPIO_OUT: gpio_o <= dat_q;
          OFF_RELOAD:   reload <= dat_q;
          OFF_CTRL: begin
            tmr_en <= dat_q[CTRL_TMR_EN];
            irq_en <= dat_q[CTRL_IRQ_EN];
          end
          default: ;
        endcase
      end
      // A fresh expiry beats a simultaneous acknowledge or W1C clear.
      if (expire) begin
        exp_flag <= 1'b1;
      end else if (int_ack_i || w1c) begin
        exp_flag <= 1'b0;
      end
      int_req_o <= exp_flag & irq_en;
    end
  end

  gumnut_tick_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .en       (tmr_en),
    .load     (wr_en && (addr_q == OFF_RELOAD)),
    .load_val (dat_q),
    .reload   (reload),
    .expire   (expire)
  );

endmodule

// File: tb/tb_gumnut_io_responder.sv
// tb/tb_gumnut_io_responder.sv - self-checking bench for gumnut_io_responder
// Purpose: drives port-bus transfers, GPIO and interrupt handshakes with
//   BASE_ADDR=8'h20, WAIT_STATES=1, PRESCALE=4; read data checked via a queue.
// Ports: none (top-level bench).
module tb_gumnut_io_responder;

  localparam logic [7:0] BASE = 8'h20;
  localparam int         WS   = 1;
  localparam int         PS   = 4;

  logic       clk = 1'b0;
  logic       rst, cyc, stb, we, ack, int_ack, int_req;
  logic [7:0] addr, wdat, rdat, gpio_in, gpio_out;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  gumnut_io_responder #(
    .BASE_ADDR  (BASE),
    .WAIT_STATES(WS),
    .PRESCALE   (PS)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .cyc_i    (cyc),
    .stb_i    (stb),
    .we_i     (we),
    .addr_i   (addr),
    .dat_i    (wdat),
    .dat_o    (rdat),
    .ack_o    (ack),
    .int_ack_i(int_ack),
    .int_req_o(int_req),
    .gpio_i   (gpio_in),
    .gpio_o   (gpio_out)
  );

  // Holds the strobe until ack (or 20 cycles), returning ack latency in cycles.
  task automatic bus_xfer(input logic [7:0] a, input logic w, input logic [7:0] d,
                          output logic acked, output logic [7:0] data, output int lat);
    acked = 1'b0;
    data  = 8'd0;
    lat   = 0;
    addr  = a;
    we    = w;
    wdat  = d;
    cyc   = 1'b1;
    stb   = 1'b1;
    while (!acked && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin
        acked = 1'b1;
        data  = rdat;
      end
    end
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic k;
    logic [7:0] r;
    int l;
    bus_xfer(a, 1'b1, d, k, r, l);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cyc = 0; stb = 0; we = 0; addr = 0; wdat = 0;
    gpio_in = 0; int_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ack); else passed++;
    checks++; if (rdat !== 8'h00) $display("FAIL reset_dat got %h want 00", rdat); else passed++;
    checks++; if (int_req !== 1'b0) $display("FAIL reset_int_req got %b want 0", int_req); else passed++;
    checks++; if (gpio_out !== 8'h00) $display("FAIL reset_gpio got %h want 00", gpio_out); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    logic k;
    logic [7:0] r, e;
    int l;
    bus_xfer(BASE, 1'b1, 8'hA5, k, r, l);
    checks++; if (k !== 1'b1) $display("FAIL wr_ack got %b want 1", k); else passed++;
    checks++; if (l != WS + 1) $display("FAIL wr_latency got %0d want %0d", l, WS + 1); else passed++;
    @(posedge clk); #1;
    checks++; if (gpio_out !== 8'hA5) $display("FAIL wr_gpio got %h want a5", gpio_out); else passed++;
    exp_q.push_back(8'hA5);
    bus_xfer(BASE, 1'b0, 8'h00, k, r, l);
    e = exp_q.pop_front();
    checks++; if (!k || r !== e) $display("FAIL rd_gpio_out ack %b got %h want %h", k, r, e); else passed++;
    // CTRL keeps only bits 1:0; reserved offsets read 0 but still ack.
    wr(BASE + 8'd3, 8'hFC);
    exp_q.push_back(8'h00);
    bus_xfer(BASE + 8'd3, 1'b0, 8'h00, k, r, l);
    e = exp_q.pop_front();
    checks++; if (!k || r !== e) $display("FAIL rd_ctrl_mask ack %b got %h want %h", k, r, e); else passed++;
    @(posedge clk); #1;
    bus_xfer(BASE + 8'd6, 1'b1, 8'hFF, k, r, l);
    @(posedge clk); #1;
    exp_q.push_back(8'h00);
    bus_xfer(BASE + 8'd6, 1'b0, 8'h00, k, r, l);
    e = exp_q.pop_front();
    checks++; if (!k || r !== e) $display("FAIL rd_reserved ack %b got %h want %h", k, r, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_unselected;
    logic k;
    logic [7:0] r;
    int l;
    bus_xfer(8'h40, 1'b1, 8'h11, k, r, l);
    checks++; if (k !== 1'b0) $display("FAIL unsel_ack got %b want 0", k); else passed++;
    @(posedge clk); #1;
    checks++; if (gpio_out !== 8'hA5) $display("FAIL unsel_gpio got %h want a5", gpio_out); else passed++;
  endtask

  task automatic test_drop_in_wait;
    logic k, seen;
    logic [7:0] r, e;
    int l;
    addr = BASE; we = 1'b1; wdat = 8'h3C; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL drop_ack got %b want 0", seen); else passed++;
    checks++; if (gpio_out !== 8'hA5) $display("FAIL drop_gpio got %h want a5", gpio_out); else passed++;
    exp_q.push_back(8'hA5);
    bus_xfer(BASE, 1'b0, 8'h00, k, r, l);
    e = exp_q.pop_front();
    checks++; if (!k || r !== e || l != WS + 1)
      $display("FAIL drop_next_read ack %b got %h lat %0d want %h lat %0d", k, r, l, e, WS + 1);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_gpio_in;
    logic k;
    logic [7:0] r, e;
    int l;
    gpio_in = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(8'h5A);
    bus_xfer(BASE + 8'd1, 1'b0, 8'h00, k, r, l);
    e = exp_q.pop_front();
    checks++; if (!k || r !== e) $display("FAIL rd_gpio_in ack %b got %h want %h", k, r, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_timer;
    logic k;
    logic [7:0] r, e;
    int l, n;
    wr(BASE + 8'd2, 8'd3);
    bus_xfer(BASE + 8'd3, 1'b1, 8'h03, k, r, l);
    // First edge below commits CTRL; 4 ticks of 4 cycles set EXP, then
    // int_req_o follows one cycle later.
    n = 0;
    while (n < 40 && !int_req) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 1 + 4 * PS + 1) $display("FAIL irq_rise got %0d want %0d", n, 1 + 4 * PS + 1); else passed++;
    int_ack = 1'b1;
    @(posedge clk); #1;
    int_ack = 1'b0;
    checks++; if (int_req !== 1'b1) $display("FAIL irq_hold1 got %b want 1", int_req); else passed++;
    @(posedge clk); #1;
    checks++; if (int_req !== 1'b0) $display("FAIL irq_fall got %b want 0", int_req); else passed++;
    exp_q.push_back(8'h00);
    bus_xfer(BASE + 8'd4, 1'b0, 8'h00, k, r, l);
    e = exp_q.pop_front();
    checks++; if (!k || r !== e) $display("FAIL rd_status_clr ack %b got %h want %h", k, r, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reload_zero;
    logic k;
    logic [7:0] r, e;
    int l, n;
    wr(BASE + 8'd3, 8'h00);
    wr(BASE + 8'd4, 8'h01);
    @(posedge clk); #1;
    checks++; if (int_req !== 1'b0) $display("FAIL w1c_int_req got %b want 0", int_req); else passed++;
    wr(BASE + 8'd2, 8'h00);
    bus_xfer(BASE + 8'd3, 1'b1, 8'h03, k, r, l);
    n = 0;
    while (n < 30 && !int_req) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (int_req !== 1'b1) $display("FAIL rz_rise got %b want 1", int_req); else passed++;
    // Expiries are PS cycles apart: aim int_ack_i at the next expiry edge.
    repeat (PS - 2) @(posedge clk);
    #1;
    int_ack = 1'b1;
    @(posedge clk); #1;
    int_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (int_req !== 1'b1) $display("FAIL rz_hold1 got %b want 1", int_req); else passed++;
    @(posedge clk); #1;
    checks++; if (int_req !== 1'b1) $display("FAIL rz_hold2 got %b want 1", int_req); else passed++;
    exp_q.push_back(8'h01);
    bus_xfer(BASE + 8'd4, 1'b0, 8'h00, k, r, l);
    e = exp_q.pop_front();
    checks++; if (!k || r !== e) $display("FAIL rz_status ack %b got %h want %h", k, r, e); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait;
    logic k, seen;
    logic [7:0] r, e;
    int l;
    addr = BASE; we = 1'b1; wdat = 8'hFF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) $display("FAIL rstw_ack got %b want 0", ack); else passed++;
    checks++; if (rdat !== 8'h00) $display("FAIL rstw_dat got %h want 00", rdat); else passed++;
    checks++; if (int_req !== 1'b0) $display("FAIL rstw_int_req got %b want 0", int_req); else passed++;
    checks++; if (gpio_out !== 8'h00) $display("FAIL rstw_gpio got %h want 00", gpio_out); else passed++;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL rstw_late_ack got %b want 0", seen); else passed++;
    exp_q.push_back(8'h00);
    bus_xfer(BASE, 1'b0, 8'h00, k, r, l);
    e = exp_q.pop_front();
    checks++; if (!k || r !== e || l != WS + 1)
      $display("FAIL rstw_idle_read ack %b got %h lat %0d want %h lat %0d", k, r, l, e, WS + 1);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_unselected;
    test_drop_in_wait;
    test_gpio_in;
    test_timer;
    test_reload_zero;
    test_reset_in_wait;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
